// File: rtl/pipeline_hazard_ctrl.sv
// Scoreboard hazard controller for the ID stage: counts in-flight writes per register,
// stalls IF_ID/ID_EX on pending sources and flushes wrong-path fetches after a taken branch.
module pipeline_hazard_ctrl #(
    parameter int unsigned IDX_W        = 4,
    parameter int unsigned NUM_REGS     = 16,
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_valid,
    input  logic [IDX_W-1:0] i_id_ra,
    input  logic [IDX_W-1:0] i_id_rb,
    input  logic [IDX_W-1:0] i_id_rc,
    input  logic             i_id_use_ra,
    input  logic             i_id_use_rb,
    input  logic             i_id_use_rc,
    input  logic             i_id_wr_rc,
    input  logic             i_ex_br_taken,
    input  logic             i_wb_we,
    input  logic [IDX_W-1:0] i_wb_rd,
    output logic             o_if_id_en,
    output logic             o_id_ex_en,
    output logic             o_id_ex_bubble,
    output logic             o_if_id_flush,
    output logic [15:0]      o_stall_cnt,
    output logic             o_sb_err
);

    localparam logic [CNT_W-1:0] CntMax    = '1;
    localparam logic [2:0]       FlushLoad = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun,
        StStall,
        StFlush
    } state_e;

    state_e           r_state;
    logic [2:0]       r_flush_cnt;
    logic [CNT_W-1:0] r_pend [NUM_REGS];
    logic [15:0]      r_stall_cnt;
    logic             r_sb_err;

    logic                w_haz;
    logic                w_issue;
    logic                w_wb_ok;
    logic                w_stall_cyc;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;

    // Hazard uses the current counters only; a same-cycle WB is seen next cycle.
    assign w_haz = i_id_valid &&
                   ((i_id_use_ra && (r_pend[i_id_ra] != '0)) ||
                    (i_id_use_rb && (r_pend[i_id_rb] != '0)) ||
                    (i_id_use_rc && (r_pend[i_id_rc] != '0)) ||
                    (i_id_wr_rc  && (r_pend[i_id_rc] == CntMax)));

    assign w_issue = i_id_valid && i_id_wr_rc && !w_haz && !i_ex_br_taken &&
                     (r_state != StFlush);

    assign w_wb_ok     = i_wb_we && (r_pend[i_wb_rd] != '0);
    assign w_stall_cyc = w_haz && (r_state != StFlush);

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_inc[i] = w_issue && (i_id_rc == IDX_W'(i));
            w_dec[i] = w_wb_ok && (i_wb_rd == IDX_W'(i));
        end
    end

    // Issue and WB hitting the same register cancel out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_pend[i] <= r_pend[i] + CNT_W'(1);
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_pend[i] <= r_pend[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sb_err <= 1'b0;
        end else if (i_wb_we && (r_pend[i_wb_rd] == '0)) begin
            r_sb_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall_cyc && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StRun;
            r_flush_cnt <= '0;
        end else if (i_ex_br_taken) begin
            r_flush_cnt <= FlushLoad;
            r_state     <= (FLUSH_CYCLES > 1) ? StFlush : StRun;
        end else begin
            case (r_state)
                StRun, StStall: begin
                    r_state <= w_haz ? StStall : StRun;
                end
                StFlush: begin
                    // Branch cycle counts as the first flush cycle.
                    if (r_flush_cnt <= 3'd1) begin
                        r_state <= StRun;
                    end
                    if (r_flush_cnt != 3'd0) begin
                        r_flush_cnt <= r_flush_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= StRun;
                end
            endcase
        end
    end

    always_comb begin
        o_if_id_en     = 1'b1;
        o_id_ex_en     = 1'b1;
        o_id_ex_bubble = 1'b0;
        o_if_id_flush  = 1'b0;
        if (i_ex_br_taken || (r_state == StFlush)) begin
            o_id_ex_bubble = 1'b1;
            o_if_id_flush  = 1'b1;
        end else if (w_haz) begin
            o_if_id_en     = 1'b0;
            o_id_ex_bubble = 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_sb_err    = r_sb_err;

endmodule
